// File: rtl/fixed_point_argmax_pkg.sv
// Shared types and helpers for the fixed-point argmax block: FSM state enum
// and the index-width helper.
package fixed_point_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Never narrower than one bit, so NUM_INPUTS=2 still gets a real index port
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fixed_point_argmax_comp.sv
// Signed magnitude compare of a sample against the running maximum.
module FIXED_POINT_COMP #(
   parameter int WIDTH = 8
) (
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   output logic                    GT,
   output logic                    EQ
);

   assign GT = (A > B);
   assign EQ = (A == B);

endmodule

// File: rtl/fixed_point_argmax.sv
// Streaming argmax over NUM_INPUTS signed fixed-point samples with a held result.
// Optional tie flag output enabled by defining FIXED_POINT_ARGMAX_TIE_FLAG_EN.
module fixed_point_argmax
   import fixed_point_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  int FRAC_BITS  = 3,
   parameter  int NUM_INPUTS = 10,
   localparam int IDX_W      = idx_width(NUM_INPUTS)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] VALUE_IN,
   input  logic             VALUE_VALID_IN,
   output logic             VALUE_READY_OUT,
   output logic [WIDTH-1:0] MAX_VALUE_OUT,
   output logic [IDX_W-1:0] MAX_INDEX_OUT,
   output logic             RESULT_VALID_OUT,
`ifdef FIXED_POINT_ARGMAX_TIE_FLAG_EN
   output logic             TIE_OUT,
`endif
   input  logic             RESULT_READY_IN
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

   if (NUM_INPUTS < 2 || NUM_INPUTS > 256 || FRAC_BITS < 0 || FRAC_BITS > WIDTH) begin : g_bad_cfg
      $error("fixed_point_argmax: illegal NUM_INPUTS or FRAC_BITS");
   end

   state_t                   r_state, w_next_state;
   logic [IDX_W-1:0]         r_count;
   logic signed [WIDTH-1:0]  r_run_max, r_max_out, w_new_max;
   logic [IDX_W-1:0]         r_run_idx, r_idx_out, w_new_idx;
   logic                     w_accept, w_first, w_last, w_take, w_gt, w_eq;

   FIXED_POINT_COMP #(.WIDTH(WIDTH)) u_comp (
      .A  (VALUE_IN),
      .B  (r_run_max),
      .GT (w_gt),
      .EQ (w_eq)
   );

   assign w_accept  = VALUE_VALID_IN && VALUE_READY_OUT;
   assign w_first   = (r_count == '0);
   assign w_last    = (r_count == LAST_IDX);
   // Index 0 loads unconditionally; later samples win only when strictly greater
   assign w_take    = w_first || w_gt;
   assign w_new_max = w_take ? VALUE_IN : r_run_max;
   assign w_new_idx = w_take ? r_count : r_run_idx;

   always_ff @(posedge CLK) begin
      if (RST) r_state <= ACCUM;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state     = r_state;
      VALUE_READY_OUT  = 1'b0;
      RESULT_VALID_OUT = 1'b0;
      case (r_state)
         ACCUM: begin
            VALUE_READY_OUT = !RST;
            if (VALUE_VALID_IN && !RST && w_last) w_next_state = HOLD;
         end
         HOLD: begin
            RESULT_VALID_OUT = 1'b1;
            if (RESULT_READY_IN) w_next_state = ACCUM;
         end
         default: w_next_state = ACCUM;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count   <= '0;
         r_run_max <= '0;
         r_run_idx <= '0;
         r_max_out <= '0;
         r_idx_out <= '0;
      end else if (w_accept) begin
         r_run_max <= w_new_max;
         r_run_idx <= w_new_idx;
         if (w_last) begin
            r_count   <= '0;
            r_max_out <= w_new_max;
            r_idx_out <= w_new_idx;
         end else begin
            r_count <= r_count + IDX_W'(1);
         end
      end
   end

   assign MAX_VALUE_OUT = r_max_out;
   assign MAX_INDEX_OUT = r_idx_out;

`ifdef FIXED_POINT_ARGMAX_TIE_FLAG_EN
   logic r_run_tie, r_tie_out, w_new_tie;

   assign w_new_tie = w_take ? 1'b0 : (w_eq ? 1'b1 : r_run_tie);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_run_tie <= 1'b0;
         r_tie_out <= 1'b0;
      end else if (w_accept) begin
         r_run_tie <= w_new_tie;
         if (w_last) r_tie_out <= w_new_tie;
      end
   end

   assign TIE_OUT = r_tie_out;
`endif

endmodule

// File: doc/fixed_point_argmax.md
FIXED_POINT_ARGMAX -- requirements
Module: fixed_point_argmax

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the signed fixed-point sample width in bits.
REQ-002 Parameter FRAC_BITS, default 3, SHALL set the fractional bit count; it is informational only, since ordering is scale-invariant.
REQ-003 Parameter NUM_INPUTS, default 10, SHALL set the number of samples per vector; legal range 2..256.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 VALUE_IN  input  WIDTH  SHALL carry the signed two's-complement sample.
REQ-007 VALUE_VALID_IN  input  1  SHALL qualify VALUE_IN.
REQ-008 VALUE_READY_OUT  output  1  SHALL indicate that the block accepts a sample this cycle.
REQ-009 MAX_VALUE_OUT  output  WIDTH  SHALL carry the largest sample of the completed vector.
REQ-010 MAX_INDEX_OUT  output  IDX_W=$clog2(NUM_INPUTS)  SHALL carry the zero-based position of MAX_VALUE_OUT.
REQ-011 RESULT_VALID_OUT  output  1  SHALL qualify MAX_VALUE_OUT and MAX_INDEX_OUT.
REQ-012 RESULT_READY_IN  input  1  SHALL be the downstream acceptance of the result.

Function
REQ-013 A sample SHALL be accepted only in a cycle where VALUE_VALID_IN and VALUE_READY_OUT are both 1.
REQ-014 FSM states SHALL be ACCUM and HOLD.
- ACCUM: VALUE_READY_OUT=1, RESULT_VALID_OUT=0.
- HOLD: VALUE_READY_OUT=0, RESULT_VALID_OUT=1.
REQ-015 A sample counter SHALL increment on each accept in ACCUM.
REQ-016 When the accepted sample has counter index NUM_INPUTS-1, the FSM SHALL go to HOLD on the next edge and the counter SHALL clear.
REQ-017 The sample at index 0 SHALL load the running max and index unconditionally.
REQ-018 Each later sample SHALL replace the running max and index only if it is strictly greater (signed compare); on a tie the lowest index SHALL be kept.
REQ-019 The result SHALL be valid exactly 1 cycle after the last sample is accepted; there is no other latency.
REQ-020 In HOLD, outputs SHALL stay stable until RESULT_READY_IN=1; on that edge the FSM SHALL return to ACCUM.
REQ-021 A RESULT_READY_IN pulse in ACCUM SHALL be ignored.
REQ-022 Idle cycles between samples (VALUE_VALID_IN=0) SHALL be allowed and SHALL leave all state unchanged.
REQ-023 MAX_VALUE_OUT and MAX_INDEX_OUT SHALL be registered, and SHALL be undefined-free (zero) before the first vector completes.
REQ-024 There SHALL be no overlap: samples offered in HOLD are not accepted, so the source must wait.

Reset
REQ-025 RST=1 at any clock edge SHALL force: state ACCUM, counter 0, running max 0, index 0, MAX_VALUE_OUT=0, MAX_INDEX_OUT=0, RESULT_VALID_OUT=0.
REQ-026 VALUE_READY_OUT SHALL be 0 while RST=1 and 1 on the first cycle after release.
REQ-027 Reset asserted mid-vector or in HOLD SHALL discard the partial or held result; the next accepted sample is index 0.

Configuration
REQ-028 Macro FIXED_POINT_ARGMAX_TIE_FLAG_EN, when defined, SHALL add output TIE_OUT (1 bit), qualified by RESULT_VALID_OUT.
- TIE_OUT=1 when at least one non-winning sample equalled the final max.
- The tie flag clears whenever the running max is replaced, sets on an equal compare, and resets to 0.
REQ-029 Without FIXED_POINT_ARGMAX_TIE_FLAG_EN, no TIE_OUT port or tie logic SHALL exist; all other behaviour is identical.

Structure
REQ-030 Shared package fixed_point_pkg SHALL hold the FSM state enum (ACCUM, HOLD) and an index-width helper function.
REQ-031 The signed compare SHALL instantiate the team's FIXED_POINT_COMP sub-module (GT/EQ outputs), comparing the sample against the running max.

Verification (WIDTH=8, FRAC_BITS=3, NUM_INPUTS=4)
REQ-032 Stream 0x08, 0xF0, 0x18, 0x10 back-to-back -> one cycle after the 4th accept, RESULT_VALID_OUT=1, MAX=0x18 (3.0), INDEX=2.
REQ-033 All-negative 0xF8, 0xE0, 0xFC, 0x80 -> MAX=0xFC (-0.5), INDEX=2; checks signed compare.
REQ-034 Ties 0x10, 0x20, 0x20, 0x05 -> INDEX=1; with the macro, TIE_OUT=1; all-distinct vector -> TIE_OUT=0.
REQ-035 Backpressure: hold RESULT_READY_IN=0 for 5 cycles while the source offers samples -> outputs stable, VALUE_READY_OUT=0, nothing accepted; after the ready pulse the next vector starts at index 0.
REQ-036 Random VALUE_VALID_IN gaps (50%) -> results identical to REQ-032.
REQ-037 Assert RST after 2 samples, then stream 0x01, 0x02, 0x03, 0x04 -> MAX=0x04, INDEX=3; no stale result appears.
